// File: rtl/shapool_pkg.sv
// shapool_pkg: shared definitions for the hash-pool scheduler.
// Holds the scheduler state enum, the default nonce width and a small state helper.
package shapool_pkg;

  localparam int DEFAULT_NONCE_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_CHECK,
    ST_FOUND,
    ST_EXHAUSTED,
    ST_HALTED
  } state_e;

  // A job has ended (by winning, running out of range, or losing to another device).
  function automatic logic is_finished(state_e s);
    return (s == ST_FOUND) || (s == ST_EXHAUSTED) || (s == ST_HALTED);
  endfunction

endpackage

// File: rtl/pool_scheduler_if.sv
// pool_scheduler_if: round handshake between the scheduler (master) and the hash-core pool (slave).
// The master launches a round with pool_start/pool_nonce; the pool answers with pool_done/pool_match.
interface pool_scheduler_if
  import shapool_pkg::*;
#(
  parameter int POOL_SIZE   = 2,
  parameter int NONCE_WIDTH = DEFAULT_NONCE_WIDTH
);

  logic                   pool_start;
  logic [NONCE_WIDTH-1:0] pool_nonce;
  logic                   pool_done;
  logic [POOL_SIZE-1:0]   pool_match;

  modport master (
    output pool_start,
    output pool_nonce,
    input  pool_done,
    input  pool_match
  );

  modport slave (
    input  pool_start,
    input  pool_nonce,
    output pool_done,
    output pool_match
  );

endinterface

// File: rtl/pool_match_encoder.sv
// pool_match_encoder: picks the lowest-numbered core that reported a match,
// ignoring cores whose nonce (base + i) lies beyond the inclusive end of the range.
module pool_match_encoder
#(
  parameter int POOL_SIZE      = 2,
  parameter int POOL_SIZE_LOG2 = 1,
  parameter int NONCE_WIDTH    = 32
) (
  input  logic [POOL_SIZE-1:0]      match,
  input  logic [NONCE_WIDTH-1:0]    base,
  input  logic [NONCE_WIDTH-1:0]    nonce_end,
  output logic                      found,
  output logic [POOL_SIZE_LOG2-1:0] index
);

  // Scan from the top so the lowest in-range match is the last one written.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    found = 1'b0;
    index = '0;
    for (int i = POOL_SIZE - 1; i >= 0; i--) begin
      // One extra bit keeps base + i from wrapping past all-ones.
      if (match[i] && (({1'b0, base} + (NONCE_WIDTH+1)'(i)) <= {1'b0, nonce_end})) begin
        found = 1'b1;
        index = POOL_SIZE_LOG2'(i);
      end
    end
  end

endmodule

// File: rtl/pool_scheduler.sv
// pool_scheduler: walks a nonce range across a pool of hash cores, one POOL_SIZE-wide
// round at a time, and reports the lowest winning nonce or gives way to another device.
// Optional feature: define SHAPOOL_ROUND_COUNTER_EN to count completed rounds on
// round_count; without it round_count is tied to 0.
module pool_scheduler
  import shapool_pkg::*;
#(
  parameter int POOL_SIZE      = 2,
  parameter int POOL_SIZE_LOG2 = 1,
  parameter int NONCE_WIDTH    = DEFAULT_NONCE_WIDTH
) (
  input  logic                   hwclk,
  input  logic                   reset_in,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [NONCE_WIDTH-1:0] nonce_start,
  input  logic [NONCE_WIDTH-1:0] nonce_end,
  pool_scheduler_if.master       pool,
  input  logic                   success_in,
  output logic                   success_out,
  input  logic                   done_in,
  output logic                   done_out,
  output logic                   result_valid,
  output logic [NONCE_WIDTH-1:0] result_nonce,
  output logic                   busy,
  output logic [31:0]            round_count
);

  state_e                   state_q, state_d;
  logic [NONCE_WIDTH-1:0]   base_q, base_d;
  logic [NONCE_WIDTH-1:0]   end_q, end_d;
  logic [NONCE_WIDTH-1:0]   result_q, result_d;
  logic [POOL_SIZE-1:0]     match_q, match_d;
  logic                     halt_pend_q, halt_pend_d;
  logic                     done_q, done_d;

  logic                     enc_found;
  logic [POOL_SIZE_LOG2-1:0] enc_index;
  logic [NONCE_WIDTH:0]     next_base_wide;

  pool_match_encoder #(
    .POOL_SIZE      (POOL_SIZE),
    .POOL_SIZE_LOG2 (POOL_SIZE_LOG2),
    .NONCE_WIDTH    (NONCE_WIDTH)
  ) u_encoder (
    .match     (match_q),
    .base      (base_q),
    .nonce_end (end_q),
    .found     (enc_found),
    .index     (enc_index)
  );

  // Base of the following round, one bit wider so an all-ones end cannot wrap to 0.
  assign next_base_wide = {1'b0, base_q} + (NONCE_WIDTH+1)'(POOL_SIZE);

  // Next-state decisions and datapath updates for the current job.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    end_d       = end_q;
    result_d    = result_q;
    match_d     = match_q;
    halt_pend_d = halt_pend_q;
    done_d      = done_in && is_finished(state_q);

    case (state_q)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_HALTED: begin
        if (job_valid) begin
          base_d      = nonce_start;
          end_d       = nonce_end;
          halt_pend_d = 1'b0;
          state_d     = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        state_d = success_in ? ST_HALTED : ST_WAIT;
      end

      ST_WAIT: begin
        // Another device's win is remembered but only acted on once the round returns.
        if (success_in) halt_pend_d = 1'b1;
        if (pool.pool_done) begin
          match_d     = pool.pool_match;
          halt_pend_d = 1'b0;
          state_d     = (halt_pend_q || success_in) ? ST_HALTED : ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (enc_found) begin
          result_d = base_q + NONCE_WIDTH'(enc_index);
          state_d  = ST_FOUND;
        end else if (success_in) begin
          state_d = ST_HALTED;
        end else if (next_base_wide > {1'b0, end_q}) begin
          state_d = ST_EXHAUSTED;
        end else begin
          base_d  = next_base_wide[NONCE_WIDTH-1:0];
          state_d = ST_LAUNCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any round in flight.
  always_ff @(posedge hwclk) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      end_q       <= '0;
      result_q    <= '0;
      match_q     <= '0;
      halt_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      base_q      <= base_d;
      end_q       <= end_d;
      result_q    <= result_d;
      match_q     <= match_d;
      halt_pend_q <= halt_pend_d;
      done_q      <= done_d;
    end
  end

`ifdef SHAPOOL_ROUND_COUNTER_EN
  logic [31:0] round_q, round_d;
  logic        job_accept;
  logic        check_entry;

  assign job_accept  = job_ready && job_valid;
  assign check_entry = (state_q == ST_WAIT) && (state_d == ST_CHECK);

  // Saturating count of rounds that reached the match check, restarted per job.
  always_comb begin
    round_d = round_q;
    if (job_accept) begin
      round_d = '0;
    end else if (check_entry && (round_q != '1)) begin
      round_d = round_q + 32'd1;
    end
  end

  // Round counter register.
  always_ff @(posedge hwclk) begin
    if (reset_in) round_q <= '0;
    else          round_q <= round_d;
  end

  assign round_count = round_q;
`else
  assign round_count = '0;
`endif

  assign job_ready       = (state_q == ST_IDLE) || is_finished(state_q);
  assign busy            = (state_q == ST_LAUNCH) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign pool.pool_start = (state_q == ST_LAUNCH);
  assign pool.pool_nonce = base_q;
  assign success_out     = (state_q == ST_FOUND);
  assign result_valid    = (state_q == ST_FOUND);
  assign result_nonce    = result_q;
  assign done_out        = done_q;

endmodule

// File: tb/tb_pool_scheduler.sv
// tb_pool_scheduler: randomized and directed stimulus for pool_scheduler, checked every
// cycle against a behavioural model of the scheduling rules, plus literal expectations
// for the hand-worked scenarios.
module tb_pool_scheduler;

  localparam int PS      = 2;
  localparam int PS_LOG2 = 1;
  localparam int NW      = 32;
`ifdef SHAPOOL_ROUND_COUNTER_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_LAUNCH = 1, P_WAIT = 2, P_CHECK = 3,
                 P_FOUND = 4, P_EXH = 5, P_HALT = 6;

  logic          hwclk = 1'b0;
  logic          reset_in = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [NW-1:0] nonce_start = '0;
  logic [NW-1:0] nonce_end = '0;
  logic          success_in = 1'b0;
  logic          success_out;
  logic          done_in = 1'b0;
  logic          done_out;
  logic          result_valid;
  logic [NW-1:0] result_nonce;
  logic          busy;
  logic [31:0]   round_count;

  pool_scheduler_if #(.POOL_SIZE(PS), .NONCE_WIDTH(NW)) pif ();

  pool_scheduler #(
    .POOL_SIZE      (PS),
    .POOL_SIZE_LOG2 (PS_LOG2),
    .NONCE_WIDTH    (NW)
  ) dut (
    .hwclk        (hwclk),
    .reset_in     (reset_in),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .nonce_start  (nonce_start),
    .nonce_end    (nonce_end),
    .pool         (pif),
    .success_in   (success_in),
    .success_out  (success_out),
    .done_in      (done_in),
    .done_out     (done_out),
    .result_valid (result_valid),
    .result_nonce (result_nonce),
    .busy         (busy),
    .round_count  (round_count)
  );

  initial forever #5 hwclk = ~hwclk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- pool responder (stimulus agent) ----------------
  logic [NW-1:0] seen_q[$];
  logic [PS-1:0] script[8];
  bit            script_en = 1'b0;
  int            lat_fixed = 1;
  int            round_idx = 0;
  int            resp_cnt  = 0;
  int            done_pulses = 0;
  logic [PS-1:0] resp_match = '0;

  initial begin
    pif.pool_done  = 1'b0;
    pif.pool_match = '0;
    forever begin
      @(negedge hwclk);
      pif.pool_done  = 1'b0;
      pif.pool_match = '0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          pif.pool_done  = 1'b1;
          pif.pool_match = resp_match;
          done_pulses++;
        end
      end
      if (pif.pool_start === 1'b1) begin
        seen_q.push_back(pif.pool_nonce);
        resp_cnt = (lat_fixed != 0) ? lat_fixed : 1 + int'($urandom % 4);
        if (script_en) resp_match = (round_idx < 8) ? script[round_idx] : '0;
        else           resp_match = ($urandom % 5 == 0) ? PS'($urandom) : '0;
        round_idx++;
      end
    end
  end

  // ---------------- behavioural reference model ----------------
  int            ph = P_IDLE;
  logic [NW-1:0] m_base = '0, m_end = '0, m_result = '0;
  logic [PS-1:0] m_match = '0;
  bit            m_pend = 1'b0, m_done = 1'b0;
  logic [31:0]   m_rc = '0;

  always @(posedge hwclk) begin : model
    bit nd, hit;
    longint unsigned b, e;
    if (reset_in) begin
      ph = P_IDLE; m_base = '0; m_end = '0; m_result = '0; m_match = '0;
      m_pend = 1'b0; m_done = 1'b0; m_rc = '0;
    end else begin
      nd = done_in && (ph == P_FOUND || ph == P_EXH || ph == P_HALT);
      case (ph)
        P_IDLE, P_FOUND, P_EXH, P_HALT:
          if (job_valid) begin
            m_base = nonce_start; m_end = nonce_end; m_pend = 1'b0; m_rc = '0; ph = P_LAUNCH;
          end
        P_LAUNCH: ph = success_in ? P_HALT : P_WAIT;
        P_WAIT: begin
          if (success_in) m_pend = 1'b1;
          if (pif.pool_done) begin
            if (m_pend) ph = P_HALT;
            else begin
              m_match = pif.pool_match;
              ph = P_CHECK;
              if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
            end
            m_pend = 1'b0;
          end
        end
        P_CHECK: begin
          b = longint'(m_base);
          e = longint'(m_end);
          hit = 1'b0;
          for (int i = 0; i < PS; i++)
            if (!hit && m_match[i] && (b + longint'(i) <= e)) begin
              hit = 1'b1;
              m_result = m_base + NW'(i);
            end
          if (hit)                         ph = P_FOUND;
          else if (success_in)             ph = P_HALT;
          else if (b + longint'(PS) > e)   ph = P_EXH;
          else begin m_base = m_base + NW'(PS); ph = P_LAUNCH; end
        end
        default: ph = P_IDLE;
      endcase
      m_done = nd;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge hwclk) begin
    if (cmp_en) begin
      check("job_ready", job_ready, (ph == P_IDLE || ph == P_FOUND || ph == P_EXH || ph == P_HALT));
      check("busy", busy, (ph == P_LAUNCH || ph == P_WAIT || ph == P_CHECK));
      check("pool_start", pif.pool_start, (ph == P_LAUNCH));
      if (ph == P_LAUNCH) check("pool_nonce", pif.pool_nonce, m_base);
      check("success_out", success_out, (ph == P_FOUND));
      check("result_valid", result_valid, (ph == P_FOUND));
      if (ph == P_FOUND) check("result_nonce", result_nonce, m_result);
      check("done_out", done_out, m_done);
      check("round_count", round_count, RC_EN ? m_rc : 32'd0);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic clear_script();
    for (int k = 0; k < 8; k++) script[k] = '0;
  endtask

  task automatic wait_ready(input string name, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (job_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge hwclk);
    end
    check(name, ok, 1'b1);
  endtask

  task automatic wait_start(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (pif.pool_start === 1'b1) begin ok = 1'b1; break; end
      @(negedge hwclk);
    end
    check(name, ok, 1'b1);
  endtask

  // Issue a job and run it to completion; rnd adds success/done/spurious-job noise.
  task automatic run_job(input logic [NW-1:0] s, input logic [NW-1:0] e, input bit rnd, input bit succ_en);
    bit ok = 1'b0;
    @(negedge hwclk);
    seen_q.delete();
    round_idx   = 0;
    job_valid   = 1'b1;
    nonce_start = s;
    nonce_end   = e;
    for (int c = 0; c < 400; c++) begin
      @(negedge hwclk);
      job_valid = 1'b0;
      if (rnd) begin
        success_in = succ_en && ($urandom % 12 == 0);
        done_in    = 1'($urandom % 2);
        if (busy && ($urandom % 8 == 0)) begin
          job_valid   = 1'b1;
          nonce_start = $urandom;
          nonce_end   = $urandom;
        end
      end
      if (job_ready === 1'b1) begin ok = 1'b1; break; end
    end
    job_valid  = 1'b0;
    success_in = 1'b0;
    check("job_finished", ok, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pulses_before;
    clear_script();
    repeat (3) @(negedge hwclk);
    reset_in = 1'b0;
    cmp_en   = 1'b1;

    // Reset state.
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_pool_start", pif.pool_start, 1'b0);
    check("rst_pool_nonce", pif.pool_nonce, 0);
    check("rst_result_valid", result_valid, 1'b0);
    check("rst_result_nonce", result_nonce, 0);
    check("rst_round_count", round_count, 0);

    // Job 0..7, no matches: rounds at 0,2,4,6 then exhausted.
    script_en = 1'b1; lat_fixed = 2; clear_script();
    run_job(32'd0, 32'd7, 1'b0, 1'b0);
    check("r26_rounds", seen_q.size(), 4);
    for (int k = 0; k < 4 && k < seen_q.size(); k++) check("r26_nonce", seen_q[k], 2 * k);
    check("r26_ready", job_ready, 1'b1);
    check("r26_no_result", result_valid, 1'b0);
    check("r26_round_count", round_count, RC_EN ? 32'd4 : 32'd0);

    // Job 100..199, both cores match on the second round: lowest wins, 102.
    clear_script(); script[1] = 2'b11;
    run_job(32'd100, 32'd199, 1'b0, 1'b0);
    check("r27_rounds", seen_q.size(), 2);
    check("r27_result", result_nonce, 32'd102);
    check("r27_valid", result_valid, 1'b1);
    check("r27_success", success_out, 1'b1);

    // Job 0..5, core 1 matches at base 4 -> nonce 5 is in range.
    clear_script(); script[2] = 2'b10;
    run_job(32'd0, 32'd5, 1'b0, 1'b0);
    check("r28a_result", result_nonce, 32'd5);
    check("r28a_valid", result_valid, 1'b1);
    // Same stimulus on 0..4 -> nonce 5 is masked, range exhausted.
    run_job(32'd0, 32'd4, 1'b0, 1'b0);
    check("r28b_rounds", seen_q.size(), 3);
    check("r28b_valid", result_valid, 1'b0);
    check("r28b_ready", job_ready, 1'b1);

    // success_in during WAIT: halt deferred to pool_done, no further rounds.
    clear_script(); lat_fixed = 4;
    @(negedge hwclk);
    seen_q.delete(); round_idx = 0;
    job_valid = 1'b1; nonce_start = 32'd0; nonce_end = 32'd99;
    @(negedge hwclk);
    job_valid = 1'b0;
    wait_start("r29_launch");
    @(negedge hwclk);
    success_in = 1'b1;
    @(negedge hwclk);
    success_in = 1'b0;
    check("r29_still_busy", busy, 1'b1);
    wait_ready("r29_halted", 20);
    repeat (4) @(negedge hwclk);
    check("r29_rounds", seen_q.size(), 1);
    check("r29_success_out", success_out, 1'b0);
    check("r29_valid", result_valid, 1'b0);
    check("r29_done_before", done_out, 1'b0);
    done_in = 1'b1;
    @(negedge hwclk);
    check("r29_done_after", done_out, 1'b1);
    done_in = 1'b0;

    // Top of the nonce space: one round, no wrap to 0.
    lat_fixed = 2;
    run_job(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (3) @(negedge hwclk);
    check("r30_rounds", seen_q.size(), 1);
    if (seen_q.size() > 0) check("r30_nonce", seen_q[0], 32'hFFFF_FFFE);
    check("r30_ready", job_ready, 1'b1);
    check("r30_valid", result_valid, 1'b0);

    // Reset during WAIT: back to idle, late pool_done ignored.
    lat_fixed = 4;
    @(negedge hwclk);
    seen_q.delete(); round_idx = 0;
    job_valid = 1'b1; nonce_start = 32'd0; nonce_end = 32'd99;
    @(negedge hwclk);
    job_valid = 1'b0;
    wait_start("r30_launch");
    @(negedge hwclk);
    reset_in = 1'b1;
    pulses_before = done_pulses;
    @(negedge hwclk);
    reset_in = 1'b0;
    check("r30_rst_ready", job_ready, 1'b1);
    check("r30_rst_busy", busy, 1'b0);
    check("r30_rst_nonce", pif.pool_nonce, 0);
    check("r30_rst_result", result_nonce, 0);
    check("r30_rst_success", success_out, 1'b0);
    repeat (6) begin
      @(negedge hwclk);
      check("r30_stale_start", pif.pool_start, 1'b0);
      check("r30_stale_busy", busy, 1'b0);
    end
    check("r30_stale_done_seen", (done_pulses > pulses_before), 1'b1);

    // Randomized jobs against the model.
    script_en = 1'b0; lat_fixed = 0;
    for (int j = 0; j < 60; j++) begin
      logic [NW-1:0] s, e;
      s = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 + NW'($urandom % 16)) : NW'($urandom);
      if ($urandom % 8 == 0) e = $urandom;
      else begin
        e = s + NW'($urandom % 16);
        if (e < s) e = 32'hFFFF_FFFF;
      end
      run_job(s, e, 1'b1, ($urandom % 3 == 0));
      repeat (2) begin
        @(negedge hwclk);
        done_in = 1'($urandom % 2);
      end
      done_in = 1'b0;
    end

    @(negedge hwclk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pool_scheduler.md
POOL_SCHEDULER -- requirements
Module: pool_scheduler

Interface
REQ-001 SHALL have parameter POOL_SIZE, default 2, number of hash cores in the pool.
REQ-002 SHALL have parameter POOL_SIZE_LOG2, default 1, log2(POOL_SIZE); index width.
REQ-003 SHALL have parameter NONCE_WIDTH, default 32, nonce width.
REQ-004 SHALL have ports (clock and reset first):
- hwclk  in  1  sole clock.
- reset_in  in  1  synchronous active-high reset.
- job_valid  in  1  new job present.
- job_ready  out  1  scheduler accepts a job.
- nonce_start  in  NONCE_WIDTH  first nonce of range.
- nonce_end  in  NONCE_WIDTH  last nonce of range, inclusive.
- pool_start  out  1  one-cycle pulse starting a pool round.
- pool_nonce  out  NONCE_WIDTH  base nonce of round; core i hashes base+i.
- pool_done  in  1  one-cycle pulse, round finished.
- pool_match  in  POOL_SIZE  per-core match flags, valid with pool_done.
- success_in  in  1  shared success line, any device won.
- success_out  out  1  this device drives shared success line.
- done_in  in  1  upstream daisy done.
- done_out  out  1  downstream daisy done.
- result_valid  out  1  result_nonce valid.
- result_nonce  out  NONCE_WIDTH  winning nonce.
- busy  out  1  job in progress.
- round_count  out  32  completed rounds (see Configuration).

Function
REQ-005 SHALL implement states IDLE, LAUNCH, WAIT, CHECK, FOUND, EXHAUSTED, HALTED.
REQ-006 IDLE: job_ready=1; job_valid=1 SHALL latch nonce_start as base and nonce_end, clear result_valid, and go to LAUNCH next cycle.
REQ-007 LAUNCH: pool_start=1 for exactly one cycle with pool_nonce=base, then WAIT.
REQ-008 WAIT: SHALL hold until pool_done=1, capture pool_match, then go to CHECK.
REQ-009 CHECK: any match SHALL go to FOUND with result_nonce = base + index of lowest-numbered set match bit.
REQ-010 CHECK, no match: if base+POOL_SIZE (computed NONCE_WIDTH+1 bits) > nonce_end, go to EXHAUSTED; otherwise base += POOL_SIZE and go to LAUNCH.
REQ-011 Range edge: the last round SHALL be issued even when it extends past nonce_end; matches on cores with base+i > nonce_end SHALL be ignored.
REQ-012 Wrap: nonce_end = all-ones SHALL terminate with no base wrap to 0.
REQ-013 FOUND: result_valid=1 and success_out=1, held until reset or next accepted job.
REQ-014 success_in=1 while in LAUNCH, WAIT or CHECK, with success_out=0, SHALL go to HALTED; in WAIT the transition SHALL be deferred until pool_done. No further pool_start is issued.
REQ-015 If success_in rises in the same cycle CHECK finds a local match, FOUND SHALL take priority.
REQ-016 EXHAUSTED and HALTED SHALL assert job_ready; job_valid SHALL restart as in IDLE.
REQ-017 done_out SHALL equal done_in AND (state is EXHAUSTED, HALTED or FOUND), registered, one cycle latency.
REQ-018 busy SHALL be 1 in LAUNCH, WAIT and CHECK only.
REQ-019 job_valid outside IDLE/EXHAUSTED/HALTED/FOUND SHALL be ignored.

Reset
REQ-020 reset_in=1 at a hwclk edge SHALL force IDLE; job_ready=1; all other outputs 0; base, result and round_count cleared.
REQ-021 Reset mid-round SHALL abandon the round; a later pool_done SHALL be ignored in IDLE.

Configuration
REQ-022 Macro SHAPOOL_ROUND_COUNTER_EN defined: round_count SHALL increment on every CHECK entry, saturating at all-ones, and clear on job accept.
REQ-023 Macro undefined: round_count SHALL be constant 0 with no counter logic.

Structure
REQ-024 State enum and NONCE_WIDTH default SHALL live in shared package shapool_pkg.
REQ-025 Lowest-index match selection, including range masking, SHALL be sub-module pool_match_encoder (outputs found, index).

Verification
REQ-026 Job 0..7, POOL_SIZE=2, never match -> four pool_start pulses with nonces 0,2,4,6, then EXHAUSTED, job_ready=1.
REQ-027 Job 100..199, pool_match=2'b11 on the second round -> result_nonce=102, result_valid=1, success_out=1.
REQ-028 Job 0..5, pool_match=2'b10 on the round at base 4 -> core 1 is base+1=5, match accepted; job 0..4 with the same stimulus -> match masked, EXHAUSTED.
REQ-029 success_in pulses during WAIT -> HALTED only after pool_done, no further pool_start; done_in=1 -> done_out=1 one cycle later.
REQ-030 Job FFFFFFFE..FFFFFFFF -> one round, no wrap, EXHAUSTED; reset_in during WAIT -> IDLE, outputs 0, stale pool_done ignored.
